// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter: increment, branch, jump, call/return via a
// small return-address stack, stall, and halt. nextAddr is combinational and feeds the PC register.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_W-1:0]              curAddr,
  input  logic                           stall,
  input  logic                           branch,
  input  logic                           taken,
  input  logic [ADDR_W-1:0]              offset,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [ADDR_W-1:0]              target,
  input  logic                           halt,
  input  logic                           resume,
  output logic [ADDR_W-1:0]              nextAddr,
  output logic                           halted,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           fault
);

  localparam int unsigned PtrW   = $clog2(STACK_DEPTH);
  localparam int unsigned DepthW = PtrW + 1;

  localparam logic [1:0] StBoot   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DepthW-1:0] depth_q;
  logic              fault_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push, pop, fault_set;
  logic [ADDR_W-1:0] inc_addr;
  logic [PtrW-1:0]   top_idx;
  logic              stack_empty, stack_full;

  assign inc_addr    = curAddr + ADDR_W'(1);
  // Low pointer bits wrap so that a full stack (depth == STACK_DEPTH) still indexes the top entry.
  assign top_idx     = depth_q[PtrW-1:0] - PtrW'(1);
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DepthW'(STACK_DEPTH));

  always_comb begin
    state_d   = state_q;
    nextAddr  = curAddr;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
    case (state_q)
      StBoot: begin
        nextAddr = ADDR_W'(RESET_ADDR);
        state_d  = StRun;
      end
      StRun: begin
        if (halt) begin
          state_d = StHalted;
        end else if (stall) begin
          nextAddr = curAddr;
        end else if (ret) begin
          if (stack_empty) begin
            fault_set = 1'b1;
            nextAddr  = inc_addr;
          end else begin
            pop      = 1'b1;
            nextAddr = stack_q[top_idx];
          end
        end else if (call) begin
          nextAddr = target;
          if (stack_full) fault_set = 1'b1;
          else            push      = 1'b1;
        end else if (jump) begin
          nextAddr = target;
        end else if (branch && taken) begin
          // Same-width add wraps modulo 2^ADDR_W, which matches sign-extended offset arithmetic.
          nextAddr = curAddr + offset;
        end else begin
          nextAddr = inc_addr;
        end
      end
      StHalted: begin
        if (resume) state_d = StRun;
      end
      default: begin
        nextAddr = ADDR_W'(RESET_ADDR);
        state_d  = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      depth_q <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_q | fault_set;
      if (push) begin
        stack_q[depth_q[PtrW-1:0]] <= inc_addr;
        depth_q                    <= depth_q + DepthW'(1);
      end else if (pop) begin
        depth_q <= depth_q - DepthW'(1);
      end
    end
  end

  assign halted = (state_q == StHalted);
  assign depth  = depth_q;
  assign fault  = fault_q;

endmodule
